// File: rtl/pipe_arb.sv
// pipe_arb: two-requester round-robin issue stage for an external fixed-latency
// pipe (pipe_ex). Registers the granted operands into the pipe, tracks each
// issued operation's owner alongside it, and returns pF as a tagged result.
module pipe_arb #(
   parameter int N   = 10,
   parameter int LAT = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [N-1:0] A0,
   input  logic [N-1:0] B0,
   input  logic [N-1:0] C0,
   input  logic [N-1:0] D0,
   input  logic [N-1:0] A1,
   input  logic [N-1:0] B1,
   input  logic [N-1:0] C1,
   input  logic [N-1:0] D1,
   output logic         gnt0,
   output logic         gnt1,
   input  logic         stop,
   output logic [N-1:0] pA,
   output logic [N-1:0] pB,
   output logic [N-1:0] pC,
   output logic [N-1:0] pD,
   input  logic [N-1:0] pF,
   output logic [N-1:0] res,
   output logic         res_v0,
   output logic         res_v1,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] c;
      logic [N-1:0] d;
   } ops_t;

   state_t       state, state_nx;
   logic         rr_last;              // 1: requester 1 was granted last (favours 0)
   logic         can_gnt;
   logic         gnt_any;
   ops_t         op_sel;
   ops_t         op_q;
   // Stage 0 sits alongside the pA..pD register; stages 1..LAT follow the
   // operation through pipe_ex, so the tail lines up with a valid pF.
   logic [LAT:0] vld_pipe;
   logic [LAT:0] id_pipe;

   // Arbitration: stop, reset and DRAIN all suppress grants; round-robin on contention.
   always_comb begin
      can_gnt = !rst && !stop && (state != DRAIN);
      gnt0    = can_gnt && req0 && (!req1 || rr_last);
      gnt1    = can_gnt && req1 && (!req0 || !rr_last);
      gnt_any = gnt0 || gnt1;
      op_sel  = '0;
      if (gnt0)      op_sel = '{a: A0, b: B0, c: C0, d: D0};
      else if (gnt1) op_sel = '{a: A1, b: B1, c: C1, d: D1};
   end

   // Round-robin pointer moves only when something is granted.
   always_ff @(posedge clk) begin
      if (rst)          rr_last <= 1'b1;
      else if (gnt_any) rr_last <= gnt1;
   end

   // Operand register into pipe_ex; a cycle without a grant issues a zero bubble.
   always_ff @(posedge clk) begin
      if (rst) op_q <= '0;
      else     op_q <= op_sel;
   end

   assign pA = op_q.a;
   assign pB = op_q.b;
   assign pC = op_q.c;
   assign pD = op_q.d;

   // In-flight tracker: valid and owner shift together every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LAT-1:0], gnt_any};
         id_pipe  <= {id_pipe[LAT-1:0], gnt1};
      end
   end

   // Result capture: res holds between results; res_v pulses for the owner only.
   always_ff @(posedge clk) begin
      if (rst) begin
         res    <= '0;
         res_v0 <= 1'b0;
         res_v1 <= 1'b0;
      end else begin
         res_v0 <= vld_pipe[LAT] && !id_pipe[LAT];
         res_v1 <= vld_pipe[LAT] &&  id_pipe[LAT];
         if (vld_pipe[LAT]) res <= pF;
      end
   end

   assign busy = (|vld_pipe) || res_v0 || res_v1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and done. Drain completes only once the last result pulse is
   // gone, so done always follows the final res_v.
   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         IDLE:  if ((req0 || req1) && !stop) state_nx = RUN;
         RUN: begin
            if (stop)                             state_nx = DRAIN;
            else if (!req0 && !req1 && !busy)     state_nx = IDLE;
         end
         DRAIN: begin
            if (!busy) begin
               state_nx = IDLE;
               done     = !rst;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pipe_arb.sv
// Bench for pipe_arb: behavioural pipe_ex model, queue scoreboard of expected
// results filled at grant time and drained by a result monitor.
module tb_pipe_arb;
   localparam int N   = 10;
   localparam int LAT = 3;

   logic         clk, rst, req0, req1, stop;
   logic [N-1:0] A0, B0, C0, D0, A1, B1, C1, D1;
   logic         gnt0, gnt1, res_v0, res_v1, busy, done;
   logic [N-1:0] pA, pB, pC, pD, pF, res;

   typedef struct {
      logic         id;
      logic [N-1:0] val;
      int           due;
   } item_t;

   item_t        q[$];
   int           errors = 0;
   int           checks = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   logic         last_g = 1'b1;
   logic         s_done, s_busy;
   logic [N-1:0] pm [LAT];

   pipe_arb #(.N(N), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .A0(A0), .B0(B0), .C0(C0), .D0(D0), .A1(A1), .B1(B1), .C1(C1), .D1(D1),
      .gnt0(gnt0), .gnt1(gnt1), .stop(stop),
      .pA(pA), .pB(pB), .pC(pC), .pD(pD), .pF(pF),
      .res(res), .res_v0(res_v0), .res_v1(res_v1), .busy(busy), .done(done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N-1:0] f(input logic [N-1:0] a, b, c, d);
      return (a + b) + (c - d);
   endfunction

   // pipe_ex model: LAT-stage delay of F
   always @(posedge clk) begin
      pm[0] <= f(pA, pB, pC, pD);
      for (int k = 1; k < LAT; k++) pm[k] <= pm[k-1];
   end
   assign pF = pm[LAT-1];

   task automatic set0(input int a, b, c, d);
      A0 = N'(a); B0 = N'(b); C0 = N'(c); D0 = N'(d);
   endtask

   task automatic set1(input int a, b, c, d);
      A1 = N'(a); B1 = N'(b); C1 = N'(c); D1 = N'(d);
   endtask

   // One clock: drive, check grant at negedge, push expected result, advance.
   task automatic cycle(input logic r0, r1, s, allow);
      logic  e0, e1;
      item_t it;
      req0 = r0; req1 = r1; stop = s;
      #4;
      e0 = 1'b0; e1 = 1'b0;
      if (allow && !s && !rst) begin
         if (r0 && r1) begin e0 = last_g; e1 = !last_g; end
         else begin e0 = r0; e1 = r1; end
      end
      checks++;
      if ({gnt0, gnt1} !== {e0, e1}) begin
         errors++;
         $display("FAIL gnt cyc=%0d got=%b%b exp=%b%b", cyc, gnt0, gnt1, e0, e1);
      end
      s_done = done;
      s_busy = busy;
      if (e0 || e1) begin
         last_g = e1;
         it.id  = e1;
         it.val = e1 ? f(A1, B1, C1, D1) : f(A0, B0, C0, D0);
         it.due = cyc + LAT + 2;
         q.push_back(it);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic monitor();
      item_t it;
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
         if (res_v0 === 1'b1 || res_v1 === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_res cyc=%0d res=%0d v=%b%b", cyc, res, res_v0, res_v1);
            end else begin
               it = q.pop_front();
               if ((res_v0 && res_v1) || res !== it.val || res_v1 !== it.id || cyc != it.due) begin
                  errors++;
                  $display("FAIL result cyc=%0d got res=%0d v=%b%b exp res=%0d id=%0d cyc=%0d",
                           cyc, res, res_v0, res_v1, it.val, it.id, it.due);
               end
            end
         end
      end
   endtask

   task automatic check_cleared(input string nm);
      checks++;
      if ({pA, pB, pC, pD} !== '0) begin
         errors++; $display("FAIL %s_operands got=%h exp=0", nm, {pA, pB, pC, pD});
      end
      checks++;
      if (res !== '0) begin
         errors++; $display("FAIL %s_res got=%0d exp=0", nm, res);
      end
      checks++;
      if ({res_v0, res_v1, done, busy} !== 4'b0) begin
         errors++; $display("FAIL %s_flags got=%b exp=0000", nm, {res_v0, res_v1, done, busy});
      end
   endtask

   task automatic do_reset();
      req0 = 0; req1 = 0; stop = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0; last_g = 1'b1;
      q.delete();
   endtask

   task automatic test_reset();
      set0(1, 2, 3, 4);
      rst = 1;
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 0; req0 = 0;
      check_cleared("reset");
   endtask

   task automatic test_single();
      int d0;
      d0 = done_cnt;
      set0(10, 12, 6, 3);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle(LAT + 4);
      checks++;
      if (res !== N'(25)) begin errors++; $display("FAIL single_res got=%0d exp=25", res); end
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL single_done got=%0d exp=0", done_cnt - d0); end
   endtask

   task automatic test_contention();
      for (int i = 0; i < 4; i++) begin
         set0(i + 1, 0, 0, 0);
         set1(100 + i, 0, 0, 0);
         cycle(1'b1, 1'b1, 1'b0, 1'b1);
      end
      idle(LAT + 4);
   endtask

   task automatic test_back_to_back();
      set1(20, 11, 1, 4);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      set1(15, 10, 8, 2);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (s_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy issue2 got=%b exp=1", s_busy); end
      set1(8, 15, 5, 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (s_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy issue3 got=%b exp=1", s_busy); end
      for (int m = 1; m <= LAT + 2; m++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1);
         checks++;
         if (s_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy m=%0d got=%b exp=1", m, s_busy); end
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", s_busy); end
      idle(2);
   endtask

   task automatic test_overflow();
      set1(0, 0, 0, 1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      set0(1023, 1, 0, 0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle(LAT + 4);
      checks++;
      if (res !== '0) begin errors++; $display("FAIL overflow_res got=%0d exp=0", res); end
   endtask

   task automatic test_drain();
      int d0;
      set0(5, 5, 0, 0);
      set1(1, 2, 3, 4);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      d0 = done_cnt;
      // stop for one cycle with req0 held; req0 stays high but no grants in DRAIN
      for (int j = 3; j <= LAT + 5; j++) begin
         cycle(1'b1, 1'b0, (j == 3), 1'b0);
         checks++;
         if (s_done !== (j == LAT + 5)) begin
            errors++; $display("FAIL drain_done j=%0d got=%b exp=%b", j, s_done, (j == LAT + 5));
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL drain_done_count got=%0d exp=1", done_cnt - d0); end
      // back in IDLE: a request is granted again
      set0(3, 3, 3, 3);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      idle(LAT + 4);
   endtask

   task automatic test_reset_mid();
      set0(7, 7, 7, 7);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      q.delete();
      rst = 1;
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      rst = 0; req0 = 0; last_g = 1'b1;
      check_cleared("midreset");
      idle(LAT + 4);
   endtask

   initial begin
      rst = 1; req0 = 0; req1 = 0; stop = 0;
      set0(0, 0, 0, 0);
      set1(0, 0, 0, 0);
      fork
         monitor();
      join_none
      @(posedge clk); #1;
      test_reset();
      test_single();
      do_reset();
      test_contention();
      test_back_to_back();
      test_overflow();
      test_drain();
      test_reset_mid();
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL missing_results got=%0d exp=0", q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
